// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite single-master initiator: turns valid/ready read/write commands into
// pipelined SINGLE transfers and returns one in-order response per command.
module ahb_lite_cmd_master #(
  parameter int          AWIDTH    = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [AWIDTH-1:0] CMD_ADDR,
  input  logic [2:0]        CMD_SIZE,
  input  logic [31:0]       CMD_WDATA,
  output logic              RSP_VALID,
  output logic              RSP_WRITE,
  output logic [31:0]       RSP_RDATA,
  output logic              RSP_ERR,
  output logic              BUSY,
  output logic [AWIDTH-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  typedef enum logic {RUN, ERR2} state_t;

  state_t            state, state_nx;
  logic              a_valid;
  logic [31:0]       a_wdata;
  logic              d_valid;
  logic              d_write;
  logic              c_pend;
  logic              c_write;
  logic [2:0]        eff_size;
  logic [AWIDTH-1:0] aligned_addr;

  always_comb begin
    eff_size = (CMD_SIZE > 3'd2) ? 3'd2 : CMD_SIZE;
    aligned_addr = CMD_ADDR;
    if (eff_size == 3'd1)      aligned_addr[0]   = 1'b0;
    else if (eff_size == 3'd2) aligned_addr[1:0] = 2'b00;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    CMD_READY = 1'b0;
    case (state)
      RUN: begin
        CMD_READY = HREADY;
        if (d_valid && !HREADY && HRESP) state_nx = ERR2;
      end
      ERR2: begin
        if (HREADY) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_valid   <= 1'b0;
      a_wdata   <= '0;
      d_valid   <= 1'b0;
      d_write   <= 1'b0;
      c_pend    <= 1'b0;
      c_write   <= 1'b0;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HSIZE     <= '0;
      HWDATA    <= '0;
      RSP_VALID <= 1'b0;
      RSP_WRITE <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      RSP_VALID <= 1'b0;
      RSP_WRITE <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
      if (state == RUN) begin
        // A cancelled command always responds before any later data phase can
        // complete: the bus is idle in the cycle after ERR2.
        if (c_pend) begin
          RSP_VALID <= 1'b1;
          RSP_WRITE <= c_write;
          RSP_ERR   <= 1'b1;
          c_pend    <= 1'b0;
        end else if (d_valid && HREADY) begin
          RSP_VALID <= 1'b1;
          RSP_WRITE <= d_write;
          RSP_ERR   <= HRESP;
          RSP_RDATA <= (!d_write && !HRESP) ? HRDATA : '0;
        end
        if (HREADY) begin
          d_valid <= a_valid;
          d_write <= HWRITE;
          if (a_valid && HWRITE) HWDATA <= a_wdata;
          a_valid <= CMD_VALID;
          if (CMD_VALID) begin
            HADDR   <= aligned_addr;
            HWRITE  <= CMD_WRITE;
            HSIZE   <= eff_size;
            a_wdata <= CMD_WDATA;
          end
        end else if (d_valid && HRESP) begin
          if (a_valid) begin
            a_valid <= 1'b0;
            c_pend  <= 1'b1;
            c_write <= HWRITE;
          end
        end
      end else begin
        if (HREADY) begin
          RSP_VALID <= 1'b1;
          RSP_WRITE <= d_write;
          RSP_ERR   <= 1'b1;
          d_valid   <= 1'b0;
        end
      end
    end
  end

  assign HTRANS    = a_valid ? 2'b10 : 2'b00;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VAL;
  assign BUSY      = a_valid | d_valid | c_pend;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Bench for ahb_lite_cmd_master: behavioural AHB slave plus a transaction-level
// model (command/response queues) checked every cycle, with directed scenarios.
module tb_ahb_lite_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_WRITE;
  logic [31:0] CMD_ADDR;
  logic [2:0]  CMD_SIZE;
  logic [31:0] CMD_WDATA;
  logic        RSP_VALID;
  logic        RSP_WRITE;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        BUSY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  always #5 HCLK = ~HCLK;

  ahb_lite_cmd_master #(.AWIDTH(32), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_SIZE(CMD_SIZE), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_WRITE(RSP_WRITE), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .BUSY(BUSY),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          acc_cyc;
  } cmd_t;

  typedef struct {
    logic        wr;
    logic        err;
    logic [31:0] rdata;
    int          acc_cyc;
  } rsp_t;

  typedef struct {
    logic        wr;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
    int          lat;
  } log_t;

  cmd_t issq[$];
  rsp_t expq[$];
  log_t rlog[$];
  int   plan_w[$];
  bit   plan_e[$];

  cmd_t dp;
  bit   dp_valid;
  int   dp_waits;
  bit   dp_err;
  bit   dp_estage;
  int   dp_hold;
  bit   errwin;
  bit   cancel_pending;
  bit   cancel_due;
  cmd_t ccmd;
  int   outstanding;
  int   cyc;
  int   n_pass;
  int   n_chk;
  bit   rnd_mode;
  bit   accepted;
  int   addr44_seen;

  function automatic logic [31:0] align(input logic [31:0] a, input logic [2:0] s);
    if (s == 3'd1) return a & ~32'h1;
    if (s >= 3'd2) return a & ~32'h3;
    return a;
  endfunction

  function automatic logic [2:0] esize(input logic [2:0] s);
    return (s > 3'd2) ? 3'd2 : s;
  endfunction

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return a + 32'h11;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic clear_model();
    issq.delete();
    expq.delete();
    dp_valid       = 1'b0;
    errwin         = 1'b0;
    cancel_pending = 1'b0;
    cancel_due     = 1'b0;
    outstanding    = 0;
  endtask

  task automatic drive_slave();
    if (!dp_valid) begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      HRDATA = $urandom;
    end else begin
      HRDATA = (dp.wr || dp_err) ? $urandom : slave_data(align(dp.addr, dp.size));
      if (dp_waits > 0)                 begin HREADY = 1'b0; HRESP = 1'b0; end
      else if (!dp_err)                 begin HREADY = 1'b1; HRESP = 1'b0; end
      else if (!dp_estage || dp_hold > 0) begin HREADY = 1'b0; HRESP = 1'b1; end
      else                              begin HREADY = 1'b1; HRESP = 1'b1; end
    end
  endtask

  task automatic pick_plan();
    int r;
    dp_estage = 1'b0;
    dp_hold   = 0;
    if (plan_w.size() > 0) begin
      dp_waits = plan_w.pop_front();
      dp_err   = plan_e.pop_front();
    end else if (rnd_mode) begin
      r        = $urandom_range(0, 9);
      dp_waits = (r < 5) ? 0 : r - 5;
      dp_err   = ($urandom_range(0, 7) == 0);
      dp_hold  = $urandom_range(0, 1);
    end else begin
      dp_waits = 0;
      dp_err   = 1'b0;
    end
  endtask

  // One clock cycle: slave drive, pre-edge checks and model update, edge, post-edge checks.
  task automatic step();
    cmd_t c;
    rsp_t r;
    log_t l;
    bit   acc;
    drive_slave();
    #1;
    chk("bus_constants", 32'({HBURST, HMASTLOCK, HPROT}), 32'({3'b000, 1'b0, 4'b0011}));
    chk("CMD_READY", 32'(CMD_READY), 32'(HREADY && !errwin));
    chk("HTRANS", 32'(HTRANS), (issq.size() > 0) ? 32'h2 : 32'h0);
    if (issq.size() > 0 && HTRANS == 2'b10) begin
      chk("HADDR", HADDR, align(issq[0].addr, issq[0].size));
      chk("HWRITE", 32'(HWRITE), 32'(issq[0].wr));
      chk("HSIZE", 32'(HSIZE), 32'(esize(issq[0].size)));
    end
    accepted = 1'b0;
    if (HRESET) begin
      @(posedge HCLK);
      cyc++;
      clear_model();
    end else begin
      acc = CMD_VALID && HREADY && !errwin;
      if (HTRANS == 2'b10 && HREADY && HADDR == 32'h44) addr44_seen++;
      if (cancel_due) begin
        r.wr = ccmd.wr; r.err = 1'b1; r.rdata = '0; r.acc_cyc = ccmd.acc_cyc;
        expq.push_back(r);
        cancel_due = 1'b0;
      end
      if (dp_valid && HREADY) begin
        if (dp.wr) chk("HWDATA", HWDATA, dp.wdata);
        r.wr = dp.wr; r.err = HRESP;
        r.rdata = (!dp.wr && !HRESP) ? HRDATA : 32'h0;
        r.acc_cyc = dp.acc_cyc;
        expq.push_back(r);
        dp_valid = 1'b0;
        if (errwin) begin
          errwin = 1'b0;
          if (cancel_pending) begin cancel_due = 1'b1; cancel_pending = 1'b0; end
        end
      end else if (dp_valid && !HREADY && HRESP && !errwin) begin
        errwin    = 1'b1;
        dp_estage = 1'b1;
        if (issq.size() > 0) begin ccmd = issq.pop_front(); cancel_pending = 1'b1; end
      end else if (dp_valid) begin
        if (dp_waits > 0) dp_waits--;
        else if (dp_err && dp_hold > 0) dp_hold--;
      end
      if (issq.size() > 0 && HREADY) begin
        dp = issq.pop_front();
        dp_valid = 1'b1;
        pick_plan();
      end
      if (acc) begin
        c.wr = CMD_WRITE; c.addr = CMD_ADDR; c.size = CMD_SIZE; c.wdata = CMD_WDATA; c.acc_cyc = cyc;
        issq.push_back(c);
        outstanding++;
        accepted = 1'b1;
      end
      @(posedge HCLK);
      cyc++;
    end
    #1;
    if (expq.size() > 0) begin
      r = expq.pop_front();
      chk("RSP_VALID", 32'(RSP_VALID), 32'h1);
      chk("RSP_WRITE", 32'(RSP_WRITE), 32'(r.wr));
      chk("RSP_ERR", 32'(RSP_ERR), 32'(r.err));
      chk("RSP_RDATA", RSP_RDATA, r.rdata);
      outstanding--;
      l.wr = RSP_WRITE; l.err = RSP_ERR; l.rdata = RSP_RDATA; l.cyc = cyc; l.lat = cyc - r.acc_cyc;
      rlog.push_back(l);
    end else begin
      chk("RSP_VALID_idle", 32'(RSP_VALID), 32'h0);
    end
    chk("BUSY", 32'(BUSY), 32'(outstanding > 0));
  endtask

  task automatic send(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata);
    CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_SIZE = size; CMD_WDATA = wdata;
    for (int i = 0; i < 40; i++) begin
      step();
      if (accepted) break;
    end
    chk("cmd_accepted", 32'(accepted), 32'h1);
  endtask

  task automatic drain();
    CMD_VALID = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (outstanding == 0 && expq.size() == 0) break;
      step();
    end
    chk("drain_outstanding", 32'(outstanding), 32'h0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_HTRANS"}, 32'(HTRANS), 32'h0);
    chk({tag, "_HADDR"}, HADDR, 32'h0);
    chk({tag, "_HWRITE"}, 32'(HWRITE), 32'h0);
    chk({tag, "_HSIZE"}, 32'(HSIZE), 32'h0);
    chk({tag, "_HWDATA"}, HWDATA, 32'h0);
    chk({tag, "_RSP"}, 32'({RSP_VALID, RSP_WRITE, RSP_ERR}), 32'h0);
    chk({tag, "_RSP_RDATA"}, RSP_RDATA, 32'h0);
    chk({tag, "_BUSY"}, 32'(BUSY), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_chk = 0; cyc = 0; rnd_mode = 1'b0; addr44_seen = 0;
    CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_SIZE = '0; CMD_WDATA = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    HRESET = 1'b1;
    clear_model();
    repeat (2) @(posedge HCLK);
    #1;
    check_reset_vals("reset");
    HRESET = 1'b0;

    // Single zero-wait write
    rlog.delete();
    send(1'b1, 32'h100, 3'd2, 32'hDEADBEEF);
    chk("wr_addr_phase", {HADDR[29:0], HTRANS}, {30'h100, 2'b10});
    chk("wr_hwrite", 32'(HWRITE), 32'h1);
    CMD_VALID = 1'b0;
    step();
    chk("wr_hwdata", HWDATA, 32'hDEADBEEF);
    drain();
    chk("wr_rsp_count", 32'(rlog.size()), 32'h1);
    if (rlog.size() == 1) begin
      chk("wr_latency", 32'(rlog[0].lat), 32'h3);
      chk("wr_rsp", {rlog[0].rdata[29:0], rlog[0].wr, rlog[0].err}, {30'h0, 1'b1, 1'b0});
    end

    // Back-to-back zero-wait reads
    rlog.delete();
    for (int i = 0; i < 4; i++) send(1'b0, 32'(i * 4), 3'd2, 32'h0);
    drain();
    chk("b2b_rsp_count", 32'(rlog.size()), 32'h4);
    if (rlog.size() == 4) begin
      chk("b2b_rdata0", rlog[0].rdata, 32'h11);
      chk("b2b_rdata1", rlog[1].rdata, 32'h15);
      chk("b2b_rdata2", rlog[2].rdata, 32'h19);
      chk("b2b_rdata3", rlog[3].rdata, 32'h1D);
      chk("b2b_back_to_back", 32'(rlog[3].cyc - rlog[0].cyc), 32'h3);
    end

    // Three data-phase wait states with a follower held in address phase
    rlog.delete();
    plan_w.push_back(3); plan_e.push_back(1'b0);
    send(1'b0, 32'h20, 3'd2, 32'h0);
    send(1'b0, 32'h24, 3'd2, 32'h0);
    send(1'b0, 32'h28, 3'd2, 32'h0);
    drain();
    chk("ws_rsp_count", 32'(rlog.size()), 32'h3);
    if (rlog.size() == 3) begin
      chk("ws_latency", 32'(rlog[0].lat), 32'h6);
      chk("ws_rdata0", rlog[0].rdata, 32'h31);
      chk("ws_rdata1", rlog[1].rdata, 32'h35);
      chk("ws_rdata2", rlog[2].rdata, 32'h39);
    end

    // ERROR on a write with a read pipelined behind it
    rlog.delete();
    addr44_seen = 0;
    plan_w.push_back(0); plan_e.push_back(1'b1);
    send(1'b1, 32'h40, 3'd2, 32'hCAFE0040);
    send(1'b0, 32'h44, 3'd2, 32'h0);
    CMD_VALID = 1'b0;
    step();
    chk("err_htrans_idle", 32'(HTRANS), 32'h0);
    drain();
    chk("err_rsp_count", 32'(rlog.size()), 32'h2);
    if (rlog.size() == 2) begin
      chk("err_rsp0", {rlog[0].rdata[29:0], rlog[0].wr, rlog[0].err}, {30'h0, 1'b1, 1'b1});
      chk("err_rsp1", {rlog[1].rdata[29:0], rlog[1].wr, rlog[1].err}, {30'h0, 1'b0, 1'b1});
      chk("err_rsp_consecutive", 32'(rlog[1].cyc - rlog[0].cyc), 32'h1);
    end
    chk("err_0x44_never_on_bus", 32'(addr44_seen), 32'h0);

    // Size clamping and address alignment
    send(1'b0, 32'h103, 3'd1, 32'h0);
    chk("align_half", {HADDR[28:0], HSIZE}, {29'h102, 3'd1});
    send(1'b0, 32'h107, 3'd5, 32'h0);
    chk("align_clamp", {HADDR[28:0], HSIZE}, {29'h104, 3'd2});
    drain();

    // Reset during a wait-stated data phase
    rlog.delete();
    plan_w.push_back(4); plan_e.push_back(1'b0);
    send(1'b0, 32'h60, 3'd2, 32'h0);
    CMD_VALID = 1'b0;
    step();
    step();
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    check_reset_vals("midreset");
    repeat (6) step();
    chk("midreset_no_rsp", 32'(rlog.size()), 32'h0);

    // Randomized traffic with wait states and errors
    rnd_mode = 1'b1;
    accepted = 1'b0;
    CMD_VALID = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!CMD_VALID || accepted) begin
        if ($urandom_range(0, 3) != 0) begin
          CMD_VALID = 1'b1;
          CMD_WRITE = 1'($urandom);
          CMD_ADDR  = $urandom & 32'h0000_0FFF;
          CMD_SIZE  = 3'($urandom_range(0, 7));
          CMD_WDATA = $urandom;
        end else begin
          CMD_VALID = 1'b0;
        end
      end
      step();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
